// File: rtl/reg_file_2r1w_if.sv
// Port bundle for reg_file_2r1w: one write port and two read ports.
// Plain level signals with no valid/ready handshake; wen qualifies exactly one write per rising edge.
interface reg_file_2r1w_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;

    modport master (
        output waddr, wen, wdata, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  waddr, wen, wdata, raddr1, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file with two combinational read ports, one synchronous write port, r0 hard-wired to zero.
// Optional write-first forwarding onto the read ports is enabled by defining REG_FILE_WRITE_BYPASS_EN.
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    reg_file_2r1w_if.slave    rf
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_act;
    logic [DATA_WIDTH-1:0] rdata1_d;
    logic [DATA_WIDTH-1:0] rdata2_d;

    assign wr_act = rf.wen && (rf.waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_act) begin
            regs_d[rf.waddr] = rf.wdata;
        end
    end

    // Reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REG_FILE_WRITE_BYPASS_EN
    logic byp_act;
    assign byp_act = wr_act && rst;

    always_comb begin
        rdata1_d = '0;
        rdata2_d = '0;
        if (rf.raddr1 != '0) begin
            rdata1_d = (byp_act && (rf.raddr1 == rf.waddr)) ? rf.wdata : regs_q[rf.raddr1];
        end
        if (rf.raddr2 != '0) begin
            rdata2_d = (byp_act && (rf.raddr2 == rf.waddr)) ? rf.wdata : regs_q[rf.raddr2];
        end
    end
`else
    always_comb begin
        rdata1_d = '0;
        rdata2_d = '0;
        if (rf.raddr1 != '0) begin
            rdata1_d = regs_q[rf.raddr1];
        end
        if (rf.raddr2 != '0) begin
            rdata2_d = regs_q[rf.raddr2];
        end
    end
`endif

    assign rf.rdata1 = rdata1_d;
    assign rf.rdata2 = rdata2_d;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus a randomized sweep against a register model.
module tb_reg_file_2r1w;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] got;
    logic [DW-1:0] exp_v;

    reg_file_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_bus ();

    reg_file_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drivers
    task automatic drive_idle();
        rf_bus.wen    = 1'b0;
        rf_bus.waddr  = '0;
        rf_bus.wdata  = '0;
        rf_bus.raddr1 = '0;
        rf_bus.raddr2 = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rf_bus.wen   = 1'b1;
        rf_bus.waddr = a;
        rf_bus.wdata = d;
        @(posedge clk);
        if (rst && a != '0) model[a] = d;
        #1;
        rf_bus.wen = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            rf_bus.raddr1 = AW'(i);
            rf_bus.raddr2 = AW'(DEPTH - 1 - i);
            exp_q.push_back(32'h0000_0000);
            exp_q.push_back(32'h0000_0000);
            #1;
            got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", i, got, exp_v);
            end
            got = rf_bus.rdata2; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_rd2 idx=%0d got=%h exp=%h", DEPTH - 1 - i, got, exp_v);
            end
        end
    endtask

    task automatic test_write_read();
        logic [AW-1:0] a1 [3];
        logic [AW-1:0] a2 [3];
        logic [DW-1:0] e1 [3];
        logic [DW-1:0] e2 [3];
        do_write(5'd5, 32'hDEAD_BEEF);
        do_write(5'd31, 32'h1234_5678);
        a1[0] = 5'd5;  a2[0] = 5'd31; e1[0] = 32'hDEAD_BEEF; e2[0] = 32'h1234_5678;
        a1[1] = 5'd5;  a2[1] = 5'd5;  e1[1] = 32'hDEAD_BEEF; e2[1] = 32'hDEAD_BEEF;
        a1[2] = 5'd31; a2[2] = 5'd6;  e1[2] = 32'h1234_5678; e2[2] = 32'h0000_0000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rf_bus.raddr1 = a1[i];
            rf_bus.raddr2 = a2[i];
            exp_q.push_back(e1[i]);
            exp_q.push_back(e2[i]);
            #1;
            got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL write_read_rd1 case=%0d got=%h exp=%h", i, got, exp_v);
            end
            got = rf_bus.rdata2; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL write_read_rd2 case=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        rf_bus.raddr1 = 5'd0;
        rf_bus.raddr2 = 5'd0;
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        #1;
        got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL zero_reg_rd1 got=%h exp=%h", got, exp_v);
        end
        got = rf_bus.rdata2; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL zero_reg_rd2 got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_write_disable();
        do_write(5'd7, 32'h0000_AAAA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rf_bus.wen    = 1'b0;
            rf_bus.waddr  = 5'd7;
            rf_bus.wdata  = 32'h5555_5555;
            rf_bus.raddr1 = 5'd7;
            rf_bus.raddr2 = 5'd7;
            @(posedge clk);
            #1;
            exp_q.push_back(32'h0000_AAAA);
            exp_q.push_back(32'h0000_AAAA);
            got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL wen_off_rd1 edge=%0d got=%h exp=%h", i, got, exp_v);
            end
            got = rf_bus.rdata2; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL wen_off_rd2 edge=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_same_cycle();
        do_write(5'd9, 32'h1111_1111);
        @(negedge clk);
        rf_bus.wen    = 1'b1;
        rf_bus.waddr  = 5'd9;
        rf_bus.wdata  = 32'h2222_2222;
        rf_bus.raddr1 = 5'd9;
        rf_bus.raddr2 = 5'd5;
`ifdef REG_FILE_WRITE_BYPASS_EN
        exp_q.push_back(32'h2222_2222);
`else
        exp_q.push_back(32'h1111_1111);
`endif
        exp_q.push_back(model[5]);
        #1;
        got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL same_cycle_before got=%h exp=%h", got, exp_v);
        end
        got = rf_bus.rdata2; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL same_cycle_other_port got=%h exp=%h", got, exp_v);
        end
        @(posedge clk);
        model[9] = 32'h2222_2222;
        #1;
        rf_bus.wen = 1'b0;
        exp_q.push_back(32'h2222_2222);
        #1;
        got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL same_cycle_after got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_reset_vs_write();
        @(negedge clk);
        rst          = 1'b0;
        rf_bus.wen   = 1'b1;
        rf_bus.waddr = 5'd3;
        rf_bus.wdata = 32'hCAFE_F00D;
        @(posedge clk);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        rst        = 1'b1;
        rf_bus.wen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i += 3) begin
            rf_bus.raddr1 = 5'd3;
            rf_bus.raddr2 = AW'(i);
            exp_q.push_back(32'h0000_0000);
            exp_q.push_back(32'h0000_0000);
            #1;
            got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL rst_vs_wr_r3 got=%h exp=%h", got, exp_v);
            end
            got = rf_bus.rdata2; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL rst_clears idx=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] wa;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] wd;
        logic          we;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we  = ($urandom_range(0, 3) != 0);
            wa  = AW'($urandom_range(0, DEPTH - 1));
            wd  = $urandom;
            ra1 = (n % 4 == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            ra2 = AW'($urandom_range(0, DEPTH - 1));
            rf_bus.wen    = we;
            rf_bus.waddr  = wa;
            rf_bus.wdata  = wd;
            rf_bus.raddr1 = ra1;
            rf_bus.raddr2 = ra2;
`ifdef REG_FILE_WRITE_BYPASS_EN
            exp_q.push_back((ra1 == '0) ? '0 : (we && wa != '0 && ra1 == wa) ? wd : model[ra1]);
            exp_q.push_back((ra2 == '0) ? '0 : (we && wa != '0 && ra2 == wa) ? wd : model[ra2]);
`else
            exp_q.push_back((ra1 == '0) ? '0 : model[ra1]);
            exp_q.push_back((ra2 == '0) ? '0 : model[ra2]);
`endif
            #1;
            got = rf_bus.rdata1; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL rand_rd1 n=%0d addr=%0d got=%h exp=%h", n, ra1, got, exp_v);
            end
            got = rf_bus.rdata2; exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL rand_rd2 n=%0d addr=%0d got=%h exp=%h", n, ra2, got, exp_v);
            end
            @(posedge clk);
            if (we && wa != '0) model[wa] = wd;
        end
        #1;
        rf_bus.wen = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive_idle();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_write_disable();
        test_same_cycle();
        test_reset_vs_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
